// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a registered result and a single-cycle done pulse.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic                spec_q, spec_d;
  logic [XLEN-1:0]     spec_val_q, spec_val_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                in_a_signed, in_b_signed, in_sa, in_sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]   mul_step, div_step, prod;
  logic [XLEN-1:0]     quo, rem, final_val;

  // Capture-side decode: operand signedness, magnitudes and forced results.
  always_comb begin
    in_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    in_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    in_sa       = in_a_signed && operand_a[XLEN-1];
    in_sb       = in_b_signed && operand_b[XLEN-1];
    mag_a       = in_sa ? -operand_a : operand_a;
    mag_b       = in_sb ? -operand_b : operand_b;
  end

  // Datapath for one CALC iteration and the FINISH sign/selection step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, b_q};
    if (!div_diff[XLEN]) begin
      div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (spec_q) begin
      final_val = spec_val_q;
    end else if (op_q[2]) begin
      final_val = op_q[1] ? rem : quo;
    end else begin
      final_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = CALC;
          cnt_d      = '0;
          op_d       = op;
          a_d        = mag_a;
          b_d        = mag_b;
          sa_d       = in_sa;
          sb_d       = in_sb;
          acc_d      = op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
          spec_d     = 1'b0;
          spec_val_d = '0;
          // Divide-by-zero and signed overflow bypass the iterative result.
          if (op[2] && (operand_b == '0)) begin
            spec_d     = 1'b1;
            spec_val_d = op[1] ? operand_a : '1;
          end else if (!op[0] && op[2] && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                       && (operand_b == '1)) begin
            spec_d     = 1'b1;
            spec_val_d = op[1] ? '0 : operand_a;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = final_val;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FINISH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
